shift_arbiter: RTL and testbench
================================

# shift_arbiter

Shares one sign-extending left-shift datapath (result = low WIDTH bits of sign-extended x shifted left by y) between two requesters. Round-robin arbitration, a single registered result stage with valid/ready backpressure, and a wrapping completion counter. Sits between the issue logic of two clients and the shifter; the shifter itself is instantiated inside as combinational logic.

## Interface
Parameters:
- WIDTH, 8, operand/result width
- SHW, 8, shift-amount width
- CNTW, 16, completion counter width

Ports:
- clock  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-high
- io_req0_valid  in  1  requester 0 has an operation
- io_req0_ready  out  1  requester 0 operation accepted this cycle when high with valid
- io_req0_x  in  WIDTH  requester 0 operand
- io_req0_y  in  SHW  requester 0 shift amount
- io_req1_valid / io_req1_ready / io_req1_x / io_req1_y  same as requester 0, for requester 1
- io_resp_valid  out  1  result register holds a result
- io_resp_ready  in  1  consumer takes result this cycle
- io_resp_bits  out  WIDTH  shifted result
- io_resp_id  out  1  requester index that issued the result
- io_count  out  CNTW  number of results consumed (resp_valid & resp_ready), wraps

## Operation
- Datapath: res = (x << y)[WIDTH-1:0]; sign extension of x to WIDTH+2^SHW-1 bits does not affect low bits; any y >= WIDTH gives 0. Unsigned y.
- Stage free: free = ~resp_valid | resp_ready (pipelined: drain and refill in same cycle allowed).
- Grant (combinational): only req0 valid -> 0; only req1 valid -> 1; both valid -> index != last; neither -> no grant.
- io_reqN_ready = free & grant==N & io_reqN_valid. Ready to a non-valid port is always 0; ready to at most one port per cycle.
- Accept (valid & ready on a port): on next edge resp_bits <= res of that port, resp_id <= N, resp_valid <= 1, last <= N.
- No accept and resp_ready & resp_valid: resp_valid <= 0; bits/id hold value.
- last updates only on accept; never on idle or stall cycles.
- io_count increments by 1 on every cycle with resp_valid & resp_ready, wraps 2^CNTW-1 -> 0; independent of acceptance.
- Requester inputs are not required to stay stable while not ready; only the accepted cycle's x/y are sampled.

## Timing
- Reset (async, immediate): resp_valid=0, resp_bits=0, resp_id=0, last=1 (req0 wins first tie), io_count=0. io_reqN_ready therefore follows valid/grant combinationally during and after reset (free=1).
- Latency: accept in cycle N -> io_resp_valid high in N+1 with result.
- Throughput: one op per cycle while io_resp_ready held high.
- Backpressure: resp_valid=1 & resp_ready=0 -> both ready outputs 0; resp_bits/resp_id/resp_valid hold.
- Simultaneous drain and accept: count increments and new result loads in same edge; resp_valid stays 1.
- Reset asserted mid-operation: held result discarded, count cleared, no response emitted after release until a new accept.
- Fairness: with both requesters continuously valid and consumer always ready, grants alternate 0,1,0,1...; no requester waits more than one accept.

## Test plan
- Reset then single op: req0 x=0x03, y=2 -> resp_valid next cycle, bits=0x0C, id=0, count=1 after ready pulse.
- Sign/overflow: x=0x81, y=1 -> 0x02; x=0xFF, y=7 -> 0x80; x=0x7F, y=8 -> 0x00; y=255 -> 0x00.
- Contention: both valid continuously, resp_ready=1, req0 x=1 y=0, req1 x=2 y=0 -> ids 0,1,0,1, bits 0x01,0x02 alternating, one result per cycle.
- Backpressure: resp_ready=0 for 3 cycles with result 0x10 held -> both ready 0, bits 0x10 stable, count unchanged; release -> count+1, next accept same cycle.
- Counter wrap: force 65536 consumed results -> io_count returns to 0x0000.
- Async reset mid-stream: assert reset between edges while resp_valid=1 -> resp_valid, bits, count immediately 0; after release first tie grants req0.

Source files
------------

// File: rtl/shift_arbiter_if.sv
// ----------------------------------------------------------------------------
// shift_arbiter_if
//
// Purpose:
//   Bundles the two requester channels, the response channel and the
//   completion counter of shift_arbiter into one interface so both ends can
//   be connected through a single port.
//
// Parameters:
//   WIDTH  operand / result width
//   SHW    shift-amount width
//   CNTW   completion counter width
//
// Signals:
//   io_req{0,1}_valid  requester has an operation
//   io_req{0,1}_ready  operation accepted this cycle (with valid)
//   io_req{0,1}_x      operand
//   io_req{0,1}_y      shift amount (unsigned)
//   io_resp_valid      result register holds a result
//   io_resp_ready      consumer takes result this cycle
//   io_resp_bits       shifted result
//   io_resp_id         requester index that issued the result
//   io_count           number of consumed results, wrapping
//
// Modports:
//   master  requester / consumer side (testbench, issue logic)
//   slave   arbiter side
// ----------------------------------------------------------------------------
interface shift_arbiter_if #(
    parameter int WIDTH = 8,
    parameter int SHW   = 8,
    parameter int CNTW  = 16
);
    logic             io_req0_valid;
    logic             io_req0_ready;
    logic [WIDTH-1:0] io_req0_x;
    logic [SHW-1:0]   io_req0_y;

    logic             io_req1_valid;
    logic             io_req1_ready;
    logic [WIDTH-1:0] io_req1_x;
    logic [SHW-1:0]   io_req1_y;

    logic             io_resp_valid;
    logic             io_resp_ready;
    logic [WIDTH-1:0] io_resp_bits;
    logic             io_resp_id;

    logic [CNTW-1:0]  io_count;

    modport master (
        output io_req0_valid, io_req0_x, io_req0_y,
        input  io_req0_ready,
        output io_req1_valid, io_req1_x, io_req1_y,
        input  io_req1_ready,
        output io_resp_ready,
        input  io_resp_valid, io_resp_bits, io_resp_id,
        input  io_count
    );

    modport slave (
        input  io_req0_valid, io_req0_x, io_req0_y,
        output io_req0_ready,
        input  io_req1_valid, io_req1_x, io_req1_y,
        output io_req1_ready,
        input  io_resp_ready,
        output io_resp_valid, io_resp_bits, io_resp_id,
        output io_count
    );
endinterface

// File: rtl/shift_arbiter.sv
// ----------------------------------------------------------------------------
// shift_arbiter
//
// Purpose:
//   Shares one left-shift datapath between two requesters. A round-robin
//   arbiter picks one valid requester per cycle, the shifted result is
//   captured in a single registered stage with valid/ready backpressure, and
//   a wrapping counter tracks how many results the consumer has taken.
//
// Parameters:
//   WIDTH  operand / result width
//   SHW    shift-amount width
//   CNTW   completion counter width
//
// Ports:
//   clock  sole clock, rising edge
//   reset  asynchronous, active-high
//   bus    shift_arbiter_if.slave (requesters, response, counter)
// ----------------------------------------------------------------------------
module shift_arbiter #(
    parameter int WIDTH = 8,
    parameter int SHW   = 8,
    parameter int CNTW  = 16
) (
    input  logic           clock,
    input  logic           reset,
    shift_arbiter_if.slave bus
);

    // Low WIDTH bits of x shifted left by y. Sign extension of x only adds
    // bits above WIDTH, so it never reaches the result; shifting by WIDTH or
    // more leaves all zeros.
    function automatic logic [WIDTH-1:0] shl(input logic [WIDTH-1:0] x,
                                             input logic [SHW-1:0]   y);
        shl = x << y;
    endfunction

    logic             resp_valid_q, resp_valid_d;
    logic [WIDTH-1:0] resp_bits_q,  resp_bits_d;
    logic             resp_id_q,    resp_id_d;
    logic             last_q,       last_d;
    logic [CNTW-1:0]  count_q,      count_d;

    logic             free;
    logic             consume;
    logic             grant_vld;
    logic             grant_id;
    logic             rdy0;
    logic             rdy1;
    logic             accept;
    logic [WIDTH-1:0] res0;
    logic [WIDTH-1:0] res1;

    always_comb begin
        res0 = shl(bus.io_req0_x, bus.io_req0_y);
        res1 = shl(bus.io_req1_x, bus.io_req1_y);

        // The stage can refill in the same cycle it drains.
        consume = resp_valid_q & bus.io_resp_ready;
        free    = ~resp_valid_q | bus.io_resp_ready;

        // On a tie the requester that did not win last time goes next.
        grant_vld = bus.io_req0_valid | bus.io_req1_valid;
        if (bus.io_req0_valid && bus.io_req1_valid) begin
            grant_id = ~last_q;
        end else begin
            grant_id = bus.io_req1_valid;
        end

        rdy0   = free & grant_vld & ~grant_id & bus.io_req0_valid;
        rdy1   = free & grant_vld &  grant_id & bus.io_req1_valid;
        accept = rdy0 | rdy1;

        resp_valid_d = resp_valid_q;
        resp_bits_d  = resp_bits_q;
        resp_id_d    = resp_id_q;
        last_d       = last_q;
        count_d      = count_q;

        if (accept) begin
            resp_valid_d = 1'b1;
            resp_bits_d  = rdy1 ? res1 : res0;
            resp_id_d    = rdy1;
            last_d       = rdy1;
        end else if (consume) begin
            resp_valid_d = 1'b0;
        end

        if (consume) begin
            count_d = count_q + CNTW'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            resp_valid_q <= 1'b0;
            resp_bits_q  <= '0;
            resp_id_q    <= 1'b0;
            last_q       <= 1'b1;
            count_q      <= '0;
        end else begin
            resp_valid_q <= resp_valid_d;
            resp_bits_q  <= resp_bits_d;
            resp_id_q    <= resp_id_d;
            last_q       <= last_d;
            count_q      <= count_d;
        end
    end

    assign bus.io_req0_ready = rdy0;
    assign bus.io_req1_ready = rdy1;
    assign bus.io_resp_valid = resp_valid_q;
    assign bus.io_resp_bits  = resp_bits_q;
    assign bus.io_resp_id    = resp_id_q;
    assign bus.io_count      = count_q;

endmodule

// File: tb/tb_shift_arbiter.sv
// ----------------------------------------------------------------------------
// tb_shift_arbiter
//
// Purpose:
//   Directed, self-checking bench for shift_arbiter. Inputs change 1 ns after
//   a rising edge; registered outputs are sampled at that point and
//   combinational readies are sampled 1 ns after the inputs change.
// ----------------------------------------------------------------------------
module tb_shift_arbiter;

    logic clock;
    logic reset;

    int checks;
    int errors;
    logic [15:0] exp_count;

    shift_arbiter_if #(.WIDTH(8), .SHW(8), .CNTW(16)) bus ();

    shift_arbiter #(.WIDTH(8), .SHW(8), .CNTW(16)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        bus.io_req0_valid = 1'b0;
        bus.io_req0_x     = 8'h00;
        bus.io_req0_y     = 8'h00;
        bus.io_req1_valid = 1'b0;
        bus.io_req1_x     = 8'h00;
        bus.io_req1_y     = 8'h00;
        bus.io_resp_ready = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        #1;
        bus.io_req0_valid = 1'b1;
        #1;
        checks++;
        if (bus.io_resp_valid !== 1'b0) begin
            errors++; $display("FAIL reset_valid got %0b exp 0", bus.io_resp_valid);
        end
        checks++;
        if (bus.io_resp_bits !== 8'h00) begin
            errors++; $display("FAIL reset_bits got %h exp 00", bus.io_resp_bits);
        end
        checks++;
        if (bus.io_resp_id !== 1'b0) begin
            errors++; $display("FAIL reset_id got %0b exp 0", bus.io_resp_id);
        end
        checks++;
        if (bus.io_count !== 16'h0000) begin
            errors++; $display("FAIL reset_count got %h exp 0000", bus.io_count);
        end
        checks++;
        if (bus.io_req0_ready !== 1'b1 || bus.io_req1_ready !== 1'b0) begin
            errors++; $display("FAIL reset_ready got %0b%0b exp 10",
                               bus.io_req0_ready, bus.io_req1_ready);
        end
        bus.io_req0_valid = 1'b0;
        #2;
        reset = 1'b0;
        exp_count = 16'h0000;
        tick();
    endtask

    task automatic test_single();
        bus.io_req0_valid = 1'b1;
        bus.io_req0_x     = 8'h03;
        bus.io_req0_y     = 8'd2;
        bus.io_resp_ready = 1'b0;
        #1;
        checks++;
        if (bus.io_req0_ready !== 1'b1 || bus.io_req1_ready !== 1'b0) begin
            errors++; $display("FAIL single_ready got %0b%0b exp 10",
                               bus.io_req0_ready, bus.io_req1_ready);
        end
        tick();
        bus.io_req0_valid = 1'b0;
        checks++;
        if (bus.io_resp_valid !== 1'b1 || bus.io_resp_bits !== 8'h0C ||
            bus.io_resp_id !== 1'b0) begin
            errors++; $display("FAIL single_resp got v=%0b bits=%h id=%0b exp v=1 bits=0c id=0",
                               bus.io_resp_valid, bus.io_resp_bits, bus.io_resp_id);
        end
        bus.io_resp_ready = 1'b1;
        tick();
        exp_count++;
        bus.io_resp_ready = 1'b0;
        checks++;
        if (bus.io_resp_valid !== 1'b0 || bus.io_count !== exp_count) begin
            errors++; $display("FAIL single_drain got v=%0b count=%h exp v=0 count=%h",
                               bus.io_resp_valid, bus.io_count, exp_count);
        end
    endtask

    task automatic test_sign_overflow();
        logic [7:0] vx [5];
        logic [7:0] vy [5];
        logic [7:0] ve [5];
        vx = '{8'h81, 8'hFF, 8'h7F, 8'h55, 8'h01};
        vy = '{8'd1,  8'd7,  8'd8,  8'd255, 8'd7};
        ve = '{8'h02, 8'h80, 8'h00, 8'h00, 8'h80};
        for (int i = 0; i < 5; i++) begin
            bus.io_req1_valid = 1'b1;
            bus.io_req1_x     = vx[i];
            bus.io_req1_y     = vy[i];
            bus.io_resp_ready = 1'b1;
            tick();
            bus.io_req1_valid = 1'b0;
            checks++;
            if (bus.io_resp_valid !== 1'b1 || bus.io_resp_bits !== ve[i] ||
                bus.io_resp_id !== 1'b1) begin
                errors++; $display("FAIL sign_vec%0d got v=%0b bits=%h id=%0b exp v=1 bits=%h id=1",
                                   i, bus.io_resp_valid, bus.io_resp_bits, bus.io_resp_id, ve[i]);
            end
            tick();
            exp_count++;
        end
        bus.io_resp_ready = 1'b0;
        checks++;
        if (bus.io_count !== exp_count) begin
            errors++; $display("FAIL sign_count got %h exp %h", bus.io_count, exp_count);
        end
    endtask

    task automatic test_contention();
        logic exp_id;
        bus.io_req0_valid = 1'b1;
        bus.io_req0_x     = 8'h01;
        bus.io_req0_y     = 8'd0;
        bus.io_req1_valid = 1'b1;
        bus.io_req1_x     = 8'h02;
        bus.io_req1_y     = 8'd0;
        bus.io_resp_ready = 1'b1;
        #1;
        // last winner was requester 1, so the tie goes to requester 0
        checks++;
        if (bus.io_req0_ready !== 1'b1 || bus.io_req1_ready !== 1'b0) begin
            errors++; $display("FAIL cont_first_ready got %0b%0b exp 10",
                               bus.io_req0_ready, bus.io_req1_ready);
        end
        exp_id = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (i > 0) exp_count++;
            checks++;
            if (bus.io_resp_valid !== 1'b1 || bus.io_resp_id !== exp_id ||
                bus.io_resp_bits !== (exp_id ? 8'h02 : 8'h01)) begin
                errors++; $display("FAIL cont_cycle%0d got v=%0b id=%0b bits=%h exp v=1 id=%0b",
                                   i, bus.io_resp_valid, bus.io_resp_id, bus.io_resp_bits, exp_id);
            end
            exp_id = ~exp_id;
        end
        checks++;
        if (bus.io_count !== exp_count) begin
            errors++; $display("FAIL cont_count got %h exp %h", bus.io_count, exp_count);
        end
        bus.io_req0_valid = 1'b0;
        bus.io_req1_valid = 1'b0;
        tick();
        exp_count++;
        bus.io_resp_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        bus.io_req0_valid = 1'b1;
        bus.io_req0_x     = 8'h01;
        bus.io_req0_y     = 8'd4;
        bus.io_resp_ready = 1'b0;
        tick();
        bus.io_req0_x     = 8'h03;
        bus.io_req0_y     = 8'd0;
        bus.io_req1_valid = 1'b1;
        bus.io_req1_x     = 8'h02;
        bus.io_req1_y     = 8'd0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (bus.io_req0_ready !== 1'b0 || bus.io_req1_ready !== 1'b0 ||
                bus.io_resp_valid !== 1'b1 || bus.io_resp_bits !== 8'h10 ||
                bus.io_resp_id !== 1'b0 || bus.io_count !== exp_count) begin
                errors++; $display("FAIL bp_hold%0d got rdy=%0b%0b v=%0b bits=%h id=%0b count=%h exp rdy=00 v=1 bits=10 id=0 count=%h",
                                   i, bus.io_req0_ready, bus.io_req1_ready, bus.io_resp_valid,
                                   bus.io_resp_bits, bus.io_resp_id, bus.io_count, exp_count);
            end
            tick();
        end
        bus.io_resp_ready = 1'b1;
        #1;
        // requester 0 won last, so the tie now goes to requester 1
        checks++;
        if (bus.io_req0_ready !== 1'b0 || bus.io_req1_ready !== 1'b1) begin
            errors++; $display("FAIL bp_release_ready got %0b%0b exp 01",
                               bus.io_req0_ready, bus.io_req1_ready);
        end
        tick();
        exp_count++;
        bus.io_req0_valid = 1'b0;
        bus.io_req1_valid = 1'b0;
        checks++;
        if (bus.io_resp_valid !== 1'b1 || bus.io_resp_bits !== 8'h02 ||
            bus.io_resp_id !== 1'b1 || bus.io_count !== exp_count) begin
            errors++; $display("FAIL bp_release got v=%0b bits=%h id=%0b count=%h exp v=1 bits=02 id=1 count=%h",
                               bus.io_resp_valid, bus.io_resp_bits, bus.io_resp_id,
                               bus.io_count, exp_count);
        end
        tick();
        exp_count++;
        bus.io_resp_ready = 1'b0;
    endtask

    task automatic test_counter_wrap();
        int n;
        bus.io_req0_valid = 1'b1;
        bus.io_req0_x     = 8'h01;
        bus.io_req0_y     = 8'd0;
        bus.io_resp_ready = 1'b1;
        tick();
        n = 65536 - int'(exp_count);
        for (int i = 0; i < n - 1; i++) begin
            tick();
            exp_count++;
        end
        checks++;
        if (bus.io_count !== 16'hFFFF) begin
            errors++; $display("FAIL wrap_max got %h exp ffff", bus.io_count);
        end
        tick();
        exp_count++;
        checks++;
        if (bus.io_count !== 16'h0000) begin
            errors++; $display("FAIL wrap_zero got %h exp 0000", bus.io_count);
        end
        bus.io_req0_valid = 1'b0;
        tick();
        exp_count++;
        bus.io_resp_ready = 1'b0;
        checks++;
        if (bus.io_count !== exp_count || bus.io_resp_valid !== 1'b0) begin
            errors++; $display("FAIL wrap_after got count=%h v=%0b exp count=%h v=0",
                               bus.io_count, bus.io_resp_valid, exp_count);
        end
    endtask

    task automatic test_async_reset();
        bus.io_req0_valid = 1'b1;
        bus.io_req0_x     = 8'h05;
        bus.io_req0_y     = 8'd1;
        bus.io_resp_ready = 1'b0;
        tick();
        bus.io_req0_valid = 1'b0;
        checks++;
        if (bus.io_resp_valid !== 1'b1 || bus.io_resp_bits !== 8'h0A) begin
            errors++; $display("FAIL arst_pre got v=%0b bits=%h exp v=1 bits=0a",
                               bus.io_resp_valid, bus.io_resp_bits);
        end
        #3;
        reset = 1'b1;
        #1;
        checks++;
        if (bus.io_resp_valid !== 1'b0 || bus.io_resp_bits !== 8'h00 ||
            bus.io_count !== 16'h0000) begin
            errors++; $display("FAIL arst_clear got v=%0b bits=%h count=%h exp v=0 bits=00 count=0000",
                               bus.io_resp_valid, bus.io_resp_bits, bus.io_count);
        end
        #1;
        reset = 1'b0;
        tick();
        checks++;
        if (bus.io_resp_valid !== 1'b0) begin
            errors++; $display("FAIL arst_no_resp got v=%0b exp 0", bus.io_resp_valid);
        end
        bus.io_req0_valid = 1'b1;
        bus.io_req0_x     = 8'h03;
        bus.io_req0_y     = 8'd0;
        bus.io_req1_valid = 1'b1;
        bus.io_req1_x     = 8'h04;
        bus.io_req1_y     = 8'd0;
        #1;
        checks++;
        if (bus.io_req0_ready !== 1'b1 || bus.io_req1_ready !== 1'b0) begin
            errors++; $display("FAIL arst_tie_ready got %0b%0b exp 10",
                               bus.io_req0_ready, bus.io_req1_ready);
        end
        tick();
        bus.io_req0_valid = 1'b0;
        bus.io_req1_valid = 1'b0;
        checks++;
        if (bus.io_resp_valid !== 1'b1 || bus.io_resp_id !== 1'b0 ||
            bus.io_resp_bits !== 8'h03) begin
            errors++; $display("FAIL arst_first got v=%0b id=%0b bits=%h exp v=1 id=0 bits=03",
                               bus.io_resp_valid, bus.io_resp_id, bus.io_resp_bits);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        exp_count = 16'h0000;
        test_reset();
        test_single();
        test_sign_overflow();
        test_contention();
        test_backpressure();
        test_counter_wrap();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
